// File: rtl/ccr_unit.sv
// Condition code register behind the ALU: per-flag capture, SETC/CLRC, branch test-and-clear, interrupt shadow stack.
// Flags are visible one cycle after the update edge; brTaken is combinational. No backpressure: every input is consumed each cycle.
module ccr_unit #(
  parameter int DEPTH   = 4,
  parameter int DEPTH_W = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               aluZero,
  input  logic               aluSign,
  input  logic               aluCarry,
  input  logic [2:0]         flagWrEn,
  input  logic               setC,
  input  logic               clrC,
  input  logic               brValid,
  input  logic [1:0]         brType,
  input  logic               intSave,
  input  logic               intRestore,
  output logic [2:0]         ccr,
  output logic               brTaken,
  output logic [DEPTH_W-1:0] stackDepth,
  output logic               stackOvf,
  output logic               stackUnf
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SLOTS = 1 << IDX_W;

  logic [2:0]       stack [SLOTS];
  logic [2:0]       alu_flags;
  logic [2:0]       ccr_upd;
  logic             full;
  logic             empty;
  logic [IDX_W-1:0] push_idx;
  logic [IDX_W-1:0] pop_idx;

  assign alu_flags = {aluCarry, aluSign, aluZero};
  assign full      = (stackDepth == DEPTH_W'(DEPTH));
  assign empty     = (stackDepth == '0);
  // Slot array is a power of two, so the modulo wrap of pop_idx at depth==DEPTH still lands on the top entry.
  assign push_idx  = stackDepth[IDX_W-1:0];
  assign pop_idx   = push_idx - IDX_W'(1);

  always_comb begin
    brTaken = 1'b0;
    if (brValid) begin
      case (brType)
        2'b01:   brTaken = ccr[0];
        2'b10:   brTaken = ccr[1];
        2'b11:   brTaken = ccr[2];
        default: brTaken = 1'b0;
      endcase
    end
  end

  // Priority order: ALU capture, then SETC/CLRC (clear wins), then taken-branch clear of the tested flag.
  always_comb begin
    ccr_upd = ccr;
    for (int i = 0; i < 3; i++) begin
      if (flagWrEn[i]) ccr_upd[i] = alu_flags[i];
    end
    if (setC) ccr_upd[2] = 1'b1;
    if (clrC) ccr_upd[2] = 1'b0;
    if (brTaken) begin
      case (brType)
        2'b01:   ccr_upd[0] = 1'b0;
        2'b10:   ccr_upd[1] = 1'b0;
        2'b11:   ccr_upd[2] = 1'b0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ccr        <= '0;
      stackDepth <= '0;
      stackOvf   <= 1'b0;
      stackUnf   <= 1'b0;
      for (int i = 0; i < SLOTS; i++) stack[i] <= '0;
    end else if (intSave && intRestore) begin
      // Simultaneous save and RTI freezes everything, including the normal flag update.
    end else if (intRestore) begin
      if (!empty) begin
        ccr        <= stack[pop_idx];
        stackDepth <= stackDepth - DEPTH_W'(1);
      end else begin
        stackUnf <= 1'b1;
      end
    end else begin
      ccr <= ccr_upd;
      if (intSave) begin
        if (!full) begin
          stack[push_idx] <= ccr;
          stackDepth      <= stackDepth + DEPTH_W'(1);
        end else begin
          stackOvf <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ccr_unit.sv
// Scenario bench for ccr_unit: expected flags are queued as stimulus is applied and popped after each update edge.
module tb_ccr_unit;

  logic       clk;
  logic       rst_n;
  logic       aluZero, aluSign, aluCarry;
  logic [2:0] flagWrEn;
  logic       setC, clrC;
  logic       brValid;
  logic [1:0] brType;
  logic       intSave, intRestore;
  logic [2:0] ccr;
  logic       brTaken;
  logic [2:0] stackDepth;
  logic       stackOvf, stackUnf;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [2:0] exp_q [$];
  logic [2:0] shadow [$];

  ccr_unit #(.DEPTH(4), .DEPTH_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .aluZero(aluZero), .aluSign(aluSign), .aluCarry(aluCarry),
    .flagWrEn(flagWrEn), .setC(setC), .clrC(clrC),
    .brValid(brValid), .brType(brType),
    .intSave(intSave), .intRestore(intRestore),
    .ccr(ccr), .brTaken(brTaken), .stackDepth(stackDepth),
    .stackOvf(stackOvf), .stackUnf(stackUnf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    {aluCarry, aluSign, aluZero} = 3'b000;
    flagWrEn   = 3'b000;
    setC       = 1'b0;
    clrC       = 1'b0;
    brValid    = 1'b0;
    brType     = 2'b00;
    intSave    = 1'b0;
    intRestore = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_alu(input logic [2:0] we, input logic [2:0] cnz);
    flagWrEn = we;
    {aluCarry, aluSign, aluZero} = cnz;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    tick();
    tick();
    tests_run++;
    if (ccr !== 3'b000 || stackDepth !== 3'd0 || stackOvf !== 1'b0 || stackUnf !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset ccr=%b depth=%0d ovf=%b unf=%b want 000/0/0/0", ccr, stackDepth, stackOvf, stackUnf);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_alu_update();
    logic [2:0] exp;
    set_alu(3'b101, 3'b111);
    exp_q.push_back(3'b101);
    tick();
    idle();
    exp = exp_q.pop_front();
    tests_run++;
    if (ccr !== exp) begin
      tests_failed++;
      $display("FAIL alu_update ccr got %b want %b", ccr, exp);
    end
  endtask

  task automatic test_setc_clrc();
    logic [2:0] exp;
    set_alu(3'b100, 3'b100);
    setC = 1'b1;
    clrC = 1'b1;
    exp_q.push_back(3'b001);
    tick();
    idle();
    exp = exp_q.pop_front();
    tests_run++;
    if (ccr !== exp) begin
      tests_failed++;
      $display("FAIL setc_clrc_both ccr got %b want %b", ccr, exp);
    end
    setC = 1'b1;
    exp_q.push_back(3'b101);
    tick();
    idle();
    exp = exp_q.pop_front();
    tests_run++;
    if (ccr !== exp) begin
      tests_failed++;
      $display("FAIL setc ccr got %b want %b", ccr, exp);
    end
    clrC = 1'b1;
    exp_q.push_back(3'b001);
    tick();
    idle();
    exp = exp_q.pop_front();
    tests_run++;
    if (ccr !== exp) begin
      tests_failed++;
      $display("FAIL clrc ccr got %b want %b", ccr, exp);
    end
  endtask

  task automatic test_branch();
    logic [2:0] exp;
    // JZ taken with ccr=001; ALU write of Z=1 in the same cycle loses to the clear.
    brValid = 1'b1;
    brType  = 2'b01;
    set_alu(3'b001, 3'b001);
    #1;
    tests_run++;
    if (brTaken !== 1'b1) begin
      tests_failed++;
      $display("FAIL jz_taken brTaken got %b want 1", brTaken);
    end
    exp_q.push_back(3'b000);
    tick();
    idle();
    exp = exp_q.pop_front();
    tests_run++;
    if (ccr !== exp) begin
      tests_failed++;
      $display("FAIL jz_clear ccr got %b want %b", ccr, exp);
    end
    brValid = 1'b1;
    brType  = 2'b10;
    #1;
    tests_run++;
    if (brTaken !== 1'b0) begin
      tests_failed++;
      $display("FAIL jn_not_taken brTaken got %b want 0", brTaken);
    end
    idle();
    set_alu(3'b111, 3'b111);
    tick();
    idle();
    // JC taken on registered C=1; bits N and Z keep their value.
    brValid = 1'b1;
    brType  = 2'b11;
    #1;
    tests_run++;
    if (brTaken !== 1'b1) begin
      tests_failed++;
      $display("FAIL jc_taken brTaken got %b want 1", brTaken);
    end
    exp_q.push_back(3'b011);
    tick();
    exp = exp_q.pop_front();
    tests_run++;
    if (ccr !== exp) begin
      tests_failed++;
      $display("FAIL jc_clear ccr got %b want %b", ccr, exp);
    end
    // With C=0 registered, an ALU carry this cycle must not make JC taken.
    set_alu(3'b100, 3'b100);
    #1;
    tests_run++;
    if (brTaken !== 1'b0) begin
      tests_failed++;
      $display("FAIL jc_uses_registered brTaken got %b want 0", brTaken);
    end
    exp_q.push_back(3'b111);
    tick();
    idle();
    exp = exp_q.pop_front();
    tests_run++;
    if (ccr !== exp) begin
      tests_failed++;
      $display("FAIL jc_alu_write ccr got %b want %b", ccr, exp);
    end
    brValid = 1'b1;
    brType  = 2'b00;
    #1;
    tests_run++;
    if (brTaken !== 1'b0) begin
      tests_failed++;
      $display("FAIL brtype_none brTaken got %b want 0", brTaken);
    end
    idle();
  endtask

  task automatic test_nested_int();
    logic [2:0] exp;
    set_alu(3'b111, 3'b010);
    tick();
    intSave = 1'b1;
    set_alu(3'b111, 3'b100);
    tick();
    set_alu(3'b111, 3'b001);
    tick();
    idle();
    tests_run++;
    if (ccr !== 3'b001 || stackDepth !== 3'd2) begin
      tests_failed++;
      $display("FAIL nested_push ccr=%b depth=%0d want 001/2", ccr, stackDepth);
    end
    intSave    = 1'b1;
    intRestore = 1'b1;
    set_alu(3'b111, 3'b111);
    tick();
    idle();
    tests_run++;
    if (ccr !== 3'b001 || stackDepth !== 3'd2 || stackOvf !== 1'b0 || stackUnf !== 1'b0) begin
      tests_failed++;
      $display("FAIL save_and_restore ccr=%b depth=%0d ovf=%b unf=%b want 001/2/0/0", ccr, stackDepth, stackOvf, stackUnf);
    end
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back(k == 0 ? 3'b100 : 3'b010);
      intRestore = 1'b1;
      set_alu(3'b111, 3'b111);
      setC = 1'b1;
      tick();
      idle();
      exp = exp_q.pop_front();
      tests_run++;
      if (ccr !== exp || stackDepth !== 3'(1 - k)) begin
        tests_failed++;
        $display("FAIL nested_pop%0d ccr=%b depth=%0d want %b/%0d", k, ccr, stackDepth, exp, 1 - k);
      end
    end
  endtask

  task automatic test_overflow_underflow();
    logic [2:0] vals [5];
    logic [2:0] exp;
    logic [2:0] cur;
    vals = '{3'b001, 3'b110, 3'b101, 3'b011, 3'b111};
    cur = ccr;
    shadow.delete();
    for (int k = 0; k < 5; k++) begin
      if (shadow.size() < 4) shadow.push_back(cur);
      intSave = 1'b1;
      set_alu(3'b111, vals[k]);
      cur = vals[k];
      tick();
    end
    idle();
    tests_run++;
    if (stackDepth !== 3'd4 || stackOvf !== 1'b1 || ccr !== 3'b111 || stackUnf !== 1'b0) begin
      tests_failed++;
      $display("FAIL overflow depth=%0d ovf=%b ccr=%b unf=%b want 4/1/111/0", stackDepth, stackOvf, ccr, stackUnf);
    end
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back(shadow.pop_back());
      intRestore = 1'b1;
      set_alu(3'b111, 3'b000);
      tick();
      idle();
      exp = exp_q.pop_front();
      tests_run++;
      if (ccr !== exp || stackDepth !== 3'(3 - k)) begin
        tests_failed++;
        $display("FAIL pop%0d ccr=%b depth=%0d want %b/%0d", k, ccr, stackDepth, exp, 3 - k);
      end
    end
    exp_q.push_back(ccr === 3'bxxx ? 3'b000 : 3'b010);
    intRestore = 1'b1;
    set_alu(3'b111, 3'b101);
    tick();
    idle();
    exp = exp_q.pop_front();
    tests_run++;
    if (ccr !== exp || stackUnf !== 1'b1 || stackDepth !== 3'd0 || stackOvf !== 1'b1) begin
      tests_failed++;
      $display("FAIL underflow ccr=%b unf=%b depth=%0d ovf=%b want %b/1/0/1", ccr, stackUnf, stackDepth, stackOvf, exp);
    end
  endtask

  task automatic test_async_reset();
    for (int k = 0; k < 3; k++) begin
      intSave = 1'b1;
      set_alu(3'b111, 3'(k + 1));
      tick();
    end
    idle();
    set_alu(3'b111, 3'b111);
    tick();
    idle();
    tests_run++;
    if (ccr !== 3'b111 || stackDepth !== 3'd3) begin
      tests_failed++;
      $display("FAIL async_setup ccr=%b depth=%0d want 111/3", ccr, stackDepth);
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (ccr !== 3'b000 || stackDepth !== 3'd0 || stackOvf !== 1'b0 || stackUnf !== 1'b0) begin
      tests_failed++;
      $display("FAIL async_reset ccr=%b depth=%0d ovf=%b unf=%b want 000/0/0/0", ccr, stackDepth, stackOvf, stackUnf);
    end
    tick();
    rst_n = 1'b1;
    tick();
    intRestore = 1'b1;
    tick();
    idle();
    tests_run++;
    if (stackUnf !== 1'b1 || ccr !== 3'b000 || stackDepth !== 3'd0) begin
      tests_failed++;
      $display("FAIL reset_discards_stack unf=%b ccr=%b depth=%0d want 1/000/0", stackUnf, ccr, stackDepth);
    end
  endtask

  initial begin
    test_reset();
    test_alu_update();
    test_setc_clrc();
    test_branch();
    test_nested_int();
    test_overflow_underflow();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/ccr_unit.md
Name: ccr_unit

Overview:
- Condition code register stage directly downstream of the ALU.
- Captures carry/sign/zero flags produced each cycle under per-flag write enables, and services SETC/CLRC instructions.
- Evaluates conditional-jump conditions (JZ/JN/JC) and clears the tested flag when a jump is taken.
- Saves/restores flags on interrupt entry/RTI via an internal LIFO shadow stack.

Parameters:
DEPTH, 4, number of shadow-stack entries (nested interrupt levels), >=1
DEPTH_W, 3, width of depth counter; must hold 0..DEPTH

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
aluZero  in  1  zero flag from ALU
aluSign  in  1  sign flag from ALU
aluCarry  in  1  carry flag from ALU
flagWrEn  in  3  per-flag ALU update mask {C,N,Z}
setC  in  1  SETC instruction: force C=1
clrC  in  1  CLRC instruction: force C=0
brValid  in  1  conditional jump present in this cycle
brType  in  2  00 none, 01 JZ, 10 JN, 11 JC
intSave  in  1  interrupt entry: push flags
intRestore  in  1  RTI: pop flags
ccr  out  3  current flags {C,N,Z}: bit2 C, bit1 N, bit0 Z
brTaken  out  1  jump condition true (combinational)
stackDepth  out  DEPTH_W  occupied shadow entries
stackOvf  out  1  sticky: push attempted when full
stackUnf  out  1  sticky: pop attempted when empty

Behaviour:
- Reset (rst_n low, async): ccr=000, stackDepth=0, all stack entries=000, stackOvf=0, stackUnf=0. Reset mid-interrupt discards all saved entries.
- brTaken = brValid & (brType==01 ? ccr[0] : brType==10 ? ccr[1] : brType==11 ? ccr[2] : 0). Evaluated on the registered ccr, never on this cycle's ALU inputs.
- Normal update (no intRestore), applied in order, last writer wins per bit:
  1. ALU: for each bit i with flagWrEn[i]=1, ccr[i] <= ALU flag.
  2. setC sets C; clrC clears C; both asserted -> clrC wins.
  3. brTaken=1 -> tested flag cleared (overrides steps 1-2 on that bit only).
- intSave alone:
  - If stackDepth<DEPTH: push the pre-update ccr value; stackDepth+1. The ccr normal update still happens the same cycle.
  - If full: no push, depth unchanged, stackOvf<=1.
- intRestore alone:
  - If stackDepth>0: ccr <= top entry; stackDepth-1; all normal updates that cycle ignored.
  - If empty: ccr unchanged, normal updates ignored, stackUnf<=1.
- intSave and intRestore together:
  - Stack and ccr unchanged; normal updates ignored; no error flags.
- Latency: flags visible on ccr one cycle after the update edge. Restored value visible the cycle after the RTI edge.
- Stack is LIFO with top = entry[stackDepth-1]. Entries above the top are don't-care but must not be read.
- stackOvf/stackUnf clear only on reset.
- Width: all flag paths 1 bit; no arithmetic except the depth counter, which never wraps (guarded by the full/empty checks).

Test Plan:
- Reset then aluZero=1, aluCarry=1, flagWrEn=101 -> ccr=101 next cycle; N untouched at 0.
- ccr=101, setC=1 and clrC=1 with flagWrEn=100, aluCarry=1 -> ccr=001.
- ccr=001, brValid=1, brType=01 -> brTaken=1 same cycle; ccr=000 next cycle, even with flagWrEn=001 and aluZero=1 that cycle.
- Nested interrupts (DEPTH=4): intSave with ccr=010, then ccr=100, intSave, then ccr=001 -> depth=2; intRestore -> ccr=100, depth=1; intRestore -> ccr=010, depth=0.
- Five consecutive intSave pulses -> depth=4, stackOvf=1. Then intRestore with depth=0 after four pops -> stackUnf=1, ccr unchanged.
- rst_n asserted low mid-cycle with depth=3, ccr=111 -> immediate ccr=000, depth=0, flags 0, without waiting for a clock edge.
